// File: rtl/boot_loader.sv
// Framed byte-stream image loader: length, payload, checksum -> instruction ROM writes.
// Keeps the core in reset until a complete image with a matching checksum has arrived.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        rom_wen_o,
  output logic [31:0] rom_waddr_o,
  output logic [31:0] rom_wdata_o,
  output logic        core_rstn_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] len;
  logic [31:0] word;
  logic [31:0] idx;
  logic [7:0]  sum;

  logic        xfer;
  logic        last_byte;
  logic [31:0] len_full;
  logic [31:0] word_full;

  assign xfer      = byte_valid_i & byte_ready_o;
  assign last_byte = (byte_cnt == 2'd3);
  // Length arrives LSB first, so shifting in from the top leaves byte 0 in [7:0].
  assign len_full  = {byte_i, len[31:8]};

  always_comb begin
    word_full = word;
    word_full[{byte_cnt, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= LEN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LEN: begin
        if (xfer && last_byte) begin
          if (len_full > 32'(DEPTH_WORDS)) state_nxt = ERR;
          else if (len_full == 32'd0)      state_nxt = CSUM;
          else                             state_nxt = DATA;
        end
      end
      DATA: begin
        if (xfer && last_byte && (idx + 32'd1 == len)) state_nxt = CSUM;
      end
      CSUM: begin
        if (xfer) state_nxt = (byte_i == sum) ? DONE : ERR;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_ready_o <= 1'b0;
      rom_wen_o    <= 1'b0;
      rom_waddr_o  <= BASE_ADDR;
      rom_wdata_o  <= 32'd0;
      core_rstn_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      byte_cnt     <= 2'd0;
      len          <= 32'd0;
      word         <= 32'd0;
      idx          <= 32'd0;
      sum          <= 8'd0;
    end else begin
      rom_wen_o    <= 1'b0;
      // Status flags follow the next state so they line up with the state register.
      byte_ready_o <= (state_nxt == LEN) || (state_nxt == DATA) || (state_nxt == CSUM);
      core_rstn_o  <= (state_nxt == DONE);
      done_o       <= (state_nxt == DONE);
      err_o        <= (state_nxt == ERR);
      if (xfer) begin
        case (state)
          LEN: begin
            len      <= len_full;
            byte_cnt <= byte_cnt + 2'd1;
          end
          DATA: begin
            word     <= word_full;
            sum      <= sum + byte_i;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              rom_wen_o   <= 1'b1;
              rom_wdata_o <= word_full;
              rom_waddr_o <= BASE_ADDR + {idx[29:0], 2'b00};
              idx         <= idx + 32'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good frame, bad checksum, oversize, empty image,
// gapped stream and mid-load reset.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        rom_wen_o;
  logic [31:0] rom_waddr_o;
  logic [31:0] rom_wdata_o;
  logic        core_rstn_o;
  logic        done_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  logic [7:0] frame1 [0:12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                8'h93, 8'h00, 8'h10, 8'h00,
                                8'h13, 8'h01, 8'h20, 8'h00, 8'hD7};

  boot_loader dut (
    .clk(clk), .rstn(rstn), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .rom_wen_o(rom_wen_o), .rom_waddr_o(rom_waddr_o),
    .rom_wdata_o(rom_wdata_o), .core_rstn_o(core_rstn_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rom_wen_o) begin
      wa.push_back(rom_waddr_o);
      wd.push_back(rom_wdata_o);
    end
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready_o) begin
      tests++; fails++;
      $display("FAIL send_timeout byte=%02h ready=%0b required 1", b, byte_ready_o);
    end else begin
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    byte_valid_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    wa.delete();
    wd.delete();
  endtask

  task automatic send_frame(input logic [7:0] csum, input int max_gap);
    for (int i = 0; i < 12; i++) begin
      send(frame1[i]);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
    send(csum);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({byte_ready_o, rom_wen_o, core_rstn_o, done_o, err_o} !== 5'b0 ||
        rom_waddr_o !== 32'h0 || rom_wdata_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs rdy=%0b wen=%0b crst=%0b done=%0b err=%0b addr=%h data=%h required all 0",
               byte_ready_o, rom_wen_o, core_rstn_o, done_o, err_o, rom_waddr_o, rom_wdata_o);
    end
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if (byte_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_rise got %0b required 1", byte_ready_o);
    end
  endtask

  task automatic test_good_frame();
    do_reset();
    send_frame(8'hD7, 0);
    tests++;
    if (done_o !== 1'b1 || core_rstn_o !== 1'b1 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL good_status done=%0b crst=%0b err=%0b required 1 1 0", done_o, core_rstn_o, err_o);
    end
    @(negedge clk);
    tests++;
    if (wa.size() != 2) begin
      fails++;
      $display("FAIL good_write_count got %0d required 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h00100093 || wa[1] !== 32'h4 || wd[1] !== 32'h00200113) begin
        fails++;
        $display("FAIL good_writes got %h:%h %h:%h required 0:00100093 4:00200113", wa[0], wd[0], wa[1], wd[1]);
      end
    end
    tests++;
    if (byte_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL good_ready_after got %0b required 0", byte_ready_o);
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    send_frame(8'hD8, 0);
    @(negedge clk);
    tests++;
    if (err_o !== 1'b1 || core_rstn_o !== 1'b0 || byte_ready_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL badcsum_status err=%0b crst=%0b rdy=%0b done=%0b required 1 0 0 0",
               err_o, core_rstn_o, byte_ready_o, done_o);
    end
    tests++;
    if (wa.size() != 2) begin
      fails++;
      $display("FAIL badcsum_write_count got %0d required 2", wa.size());
    end
    repeat (5) @(negedge clk);
    tests++;
    if (err_o !== 1'b1 || core_rstn_o !== 1'b0) begin
      fails++;
      $display("FAIL badcsum_sticky err=%0b crst=%0b required 1 0", err_o, core_rstn_o);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send(8'h01); send(8'h10); send(8'h00); send(8'h00);
    tests++;
    if (err_o !== 1'b1 || byte_ready_o !== 1'b0 || core_rstn_o !== 1'b0) begin
      fails++;
      $display("FAIL oversize_status err=%0b rdy=%0b crst=%0b required 1 0 0", err_o, byte_ready_o, core_rstn_o);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (wa.size() != 0) begin
      fails++;
      $display("FAIL oversize_writes got %0d required 0", wa.size());
    end
  endtask

  task automatic test_empty();
    do_reset();
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    tests++;
    if (err_o !== 1'b0 || done_o !== 1'b0 || byte_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL empty_len_state err=%0b done=%0b rdy=%0b required 0 0 1", err_o, done_o, byte_ready_o);
    end
    send(8'h00);
    tests++;
    if (done_o !== 1'b1 || core_rstn_o !== 1'b1 || wa.size() != 0) begin
      fails++;
      $display("FAIL empty_done done=%0b crst=%0b writes=%0d required 1 1 0", done_o, core_rstn_o, wa.size());
    end
    do_reset();
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h01);
    tests++;
    if (err_o !== 1'b1 || done_o !== 1'b0 || core_rstn_o !== 1'b0) begin
      fails++;
      $display("FAIL empty_badcsum err=%0b done=%0b crst=%0b required 1 0 0", err_o, done_o, core_rstn_o);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send_frame(8'hD7, 5);
    tests++;
    if (done_o !== 1'b1 || core_rstn_o !== 1'b1) begin
      fails++;
      $display("FAIL gaps_status done=%0b crst=%0b required 1 1", done_o, core_rstn_o);
    end
    @(negedge clk);
    tests++;
    if (wa.size() != 2) begin
      fails++;
      $display("FAIL gaps_write_count got %0d required 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h00100093 || wa[1] !== 32'h4 || wd[1] !== 32'h00200113) begin
        fails++;
        $display("FAIL gaps_writes got %h:%h %h:%h required 0:00100093 4:00200113", wa[0], wd[0], wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 10; i++) send(frame1[i]);
    @(negedge clk);
    tests++;
    if (wa.size() != 1) begin
      fails++;
      $display("FAIL midrst_partial_writes got %0d required 1", wa.size());
    end
    rstn = 1'b0;
    @(negedge clk);
    tests++;
    if ({byte_ready_o, rom_wen_o, core_rstn_o, done_o, err_o} !== 5'b0 ||
        rom_waddr_o !== 32'h0 || rom_wdata_o !== 32'h0) begin
      fails++;
      $display("FAIL midrst_outputs rdy=%0b wen=%0b crst=%0b done=%0b err=%0b addr=%h data=%h required all 0",
               byte_ready_o, rom_wen_o, core_rstn_o, done_o, err_o, rom_waddr_o, rom_wdata_o);
    end
    rstn = 1'b1;
    @(negedge clk);
    wa.delete();
    wd.delete();
    send_frame(8'hD7, 0);
    tests++;
    if (done_o !== 1'b1) begin
      fails++;
      $display("FAIL midrst_done got %0b required 1", done_o);
    end
    @(negedge clk);
    tests++;
    if (wa.size() != 2) begin
      fails++;
      $display("FAIL midrst_write_count got %0d required 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h00100093 || wa[1] !== 32'h4 || wd[1] !== 32'h00200113) begin
        fails++;
        $display("FAIL midrst_writes got %h:%h %h:%h required 0:00100093 4:00200113", wa[0], wd[0], wa[1], wd[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_oversize();
    test_empty();
    test_gaps();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
